// File: rtl/uart_reg_bank_if.sv
// Byte-stream (RX/TX FIFO) and status-read handshake signals of uart_reg_bank.
// The slave modport is the register bank; master is the surrounding fabric.
interface uart_reg_bank_if #(
  parameter int DATA_W = 32
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              read_req;
  logic              read_ack;
  logic [7:0]        uart_rd_addr;
  logic [DATA_W-1:0] status_bus;

  modport slave (
    input  rx_data, rx_valid, tx_ready, read_ack, status_bus,
    output rx_ready, tx_data, tx_valid, read_req, uart_rd_addr
  );

  modport master (
    output rx_data, rx_valid, tx_ready, read_ack, status_bus,
    input  rx_ready, tx_data, tx_valid, read_req, uart_rd_addr
  );
endinterface

// File: rtl/uart_reg_bank.sv
// UART command decoder with a parametrised control register bank, bounded
// status-read handshake, inter-byte frame timeout and saturating error count.
module uart_reg_bank #(
  parameter int                          NUM_REGS = 14,
  parameter int                          DATA_W   = 32,
  parameter logic [NUM_REGS*DATA_W-1:0]  DFT_CTRL = '0,
  parameter int                          ACK_TO   = 1024,
  parameter int                          FRAME_TO = 65535
) (
  input  logic                         clk,
  input  logic                         rst,
  uart_reg_bank_if.slave               bus,
  output logic [NUM_REGS*DATA_W-1:0]   ctrl_bus,
  output logic [NUM_REGS-1:0]          wr_strobe,
  output logic [7:0]                   err_cnt
);

  localparam int         NB     = DATA_W / 8;
  localparam int         MAX_TO = (ACK_TO > FRAME_TO) ? ACK_TO : FRAME_TO;
  localparam int         TO_W   = $clog2(MAX_TO + 1);
  localparam logic [7:0] CMD_WR = 8'hA5;
  localparam logic [7:0] CMD_RD = 8'h5A;

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_WDATA, S_LOCAL, S_RD_REQ, S_RD_WAIT, S_TX
  } state_t;

  state_t                       state_q, state_d;
  logic                         is_wr_q, is_wr_d;
  logic [7:0]                   addr_q, addr_d;
  logic [7:0]                   rd_addr_q, rd_addr_d;
  logic [2:0]                   byte_cnt_q, byte_cnt_d;
  logic [DATA_W-1:0]            stage_q, stage_d;
  logic [DATA_W-1:0]            tx_shift_q, tx_shift_d;
  logic [TO_W-1:0]              to_cnt_q, to_cnt_d;
  logic [7:0]                   err_q, err_d;
  logic [NUM_REGS*DATA_W-1:0]   ctrl_q, ctrl_d;
  logic [NUM_REGS-1:0]          strobe_q, strobe_d;

  logic              rx_fire;
  logic              tx_fire;
  logic              wr_commit;
  logic              err_inc;
  logic              frame_expired;
  logic              ack_expired;
  logic              addr_local;
  logic [DATA_W-1:0] local_word;

  assign bus.rx_ready     = (state_q == S_IDLE) || (state_q == S_ADDR) || (state_q == S_WDATA);
  assign bus.tx_valid     = (state_q == S_TX);
  assign bus.tx_data      = tx_shift_q[DATA_W-1 -: 8];
  assign bus.read_req     = (state_q == S_RD_REQ) || (state_q == S_RD_WAIT);
  assign bus.uart_rd_addr = rd_addr_q;

  assign rx_fire       = bus.rx_valid && bus.rx_ready;
  assign tx_fire       = bus.tx_valid && bus.tx_ready;
  assign addr_local    = (addr_q < 8'(NUM_REGS));
  assign frame_expired = (to_cnt_q == TO_W'(FRAME_TO - 1));
  assign ack_expired   = (to_cnt_q == TO_W'(ACK_TO - 1));

  assign ctrl_bus  = ctrl_q;
  assign wr_strobe = strobe_q;
  assign err_cnt   = err_q;

  // Read-back mux for local register reads.
  always_comb begin
    local_word = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (addr_q == 8'(i)) local_word = ctrl_q[i*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    state_d    = state_q;
    is_wr_d    = is_wr_q;
    addr_d     = addr_q;
    rd_addr_d  = rd_addr_q;
    byte_cnt_d = byte_cnt_q;
    stage_d    = stage_q;
    tx_shift_d = tx_shift_q;
    wr_commit  = 1'b0;
    err_inc    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (rx_fire) begin
          if ((bus.rx_data == CMD_WR) || (bus.rx_data == CMD_RD)) begin
            is_wr_d = (bus.rx_data == CMD_WR);
            state_d = S_ADDR;
          end else begin
            err_inc = 1'b1;
          end
        end
      end

      S_ADDR: begin
        if (rx_fire) begin
          addr_d     = bus.rx_data;
          byte_cnt_d = '0;
          if (is_wr_q) begin
            state_d = S_WDATA;
          end else if (bus.rx_data < 8'(NUM_REGS)) begin
            state_d = S_LOCAL;
          end else begin
            rd_addr_d = bus.rx_data;
            state_d   = S_RD_REQ;
          end
        end else if (frame_expired) begin
          err_inc = 1'b1;
          state_d = S_IDLE;
        end
      end

      S_WDATA: begin
        if (rx_fire) begin
          stage_d    = (stage_q << 8) | DATA_W'(bus.rx_data);
          byte_cnt_d = byte_cnt_q + 3'd1;
          if (byte_cnt_q == 3'(NB - 1)) begin
            state_d = S_IDLE;
            if (addr_local) wr_commit = 1'b1;
            else            err_inc   = 1'b1;
          end
        end else if (frame_expired) begin
          err_inc = 1'b1;
          state_d = S_IDLE;
        end
      end

      S_LOCAL: begin
        tx_shift_d = local_word;
        byte_cnt_d = '0;
        state_d    = S_TX;
      end

      // An ack arriving in the very first request cycle is honoured.
      S_RD_REQ, S_RD_WAIT: begin
        byte_cnt_d = '0;
        if (bus.read_ack) begin
          tx_shift_d = bus.status_bus;
          state_d    = S_TX;
        end else if (ack_expired) begin
          tx_shift_d = '1;
          err_inc    = 1'b1;
          state_d    = S_TX;
        end else begin
          state_d = S_RD_WAIT;
        end
      end

      S_TX: begin
        if (tx_fire) begin
          tx_shift_d = tx_shift_q << 8;
          byte_cnt_d = byte_cnt_q + 3'd1;
          if (byte_cnt_q == 3'(NB - 1)) state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Shared idle/ack timer: cleared on any accepted byte and on state entry,
  // except that RD_REQ -> RD_WAIT continues the same ack wait.
  always_comb begin
    to_cnt_d = '0;
    if (((state_q == S_ADDR) || (state_q == S_WDATA) ||
         (state_q == S_RD_REQ) || (state_q == S_RD_WAIT)) &&
        !rx_fire && ((state_d == state_q) || (state_d == S_RD_WAIT))) begin
      to_cnt_d = to_cnt_q + 1'b1;
    end
  end

  always_comb begin
    err_d = err_q;
    if (err_inc && (err_q != 8'hFF)) err_d = err_q + 8'd1;
  end

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
    logic hit;
    assign hit                           = wr_commit && (addr_q == 8'(gi));
    assign ctrl_d[gi*DATA_W +: DATA_W]   = hit ? stage_d : ctrl_q[gi*DATA_W +: DATA_W];
    assign strobe_d[gi]                  = hit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      is_wr_q    <= 1'b0;
      addr_q     <= '0;
      rd_addr_q  <= '0;
      byte_cnt_q <= '0;
      stage_q    <= '0;
      tx_shift_q <= '0;
      to_cnt_q   <= '0;
      err_q      <= '0;
      ctrl_q     <= DFT_CTRL;
      strobe_q   <= '0;
    end else begin
      state_q    <= state_d;
      is_wr_q    <= is_wr_d;
      addr_q     <= addr_d;
      rd_addr_q  <= rd_addr_d;
      byte_cnt_q <= byte_cnt_d;
      stage_q    <= stage_d;
      tx_shift_q <= tx_shift_d;
      to_cnt_q   <= to_cnt_d;
      err_q      <= err_d;
      ctrl_q     <= ctrl_d;
      strobe_q   <= strobe_d;
    end
  end

endmodule

// File: tb/tb_uart_reg_bank.sv
// Self-checking bench for uart_reg_bank: directed scenarios plus randomized
// frames checked against a register-array / error-count reference model.
`timescale 1ns/1ps
module tb_uart_reg_bank;
  localparam int NUM_REGS = 14;
  localparam int DATA_W   = 32;
  localparam int NB       = DATA_W / 8;
  localparam int ACK_TO   = 40;
  localparam int FRAME_TO = 30;
  localparam int W        = NUM_REGS * DATA_W;
  localparam logic [W-1:0] DFT = (W'(32'h12345678) << (3 * DATA_W)) | W'(32'h0BADF00D);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_reg_bank_if #(.DATA_W(DATA_W)) bus ();
  logic [W-1:0]        ctrl_bus;
  logic [NUM_REGS-1:0] wr_strobe;
  logic [7:0]          err_cnt;

  uart_reg_bank #(
    .NUM_REGS(NUM_REGS), .DATA_W(DATA_W), .DFT_CTRL(DFT),
    .ACK_TO(ACK_TO), .FRAME_TO(FRAME_TO)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .ctrl_bus(ctrl_bus), .wr_strobe(wr_strobe), .err_cnt(err_cnt)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int strobe_pulses = 0;
  int model_err;
  logic [DATA_W-1:0] model_regs [NUM_REGS];
  logic [W-1:0] dft_v;

  always @(negedge clk) if (wr_strobe !== '0) strobe_pulses <= strobe_pulses + 1;

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [W-1:0] model_flat();
    logic [W-1:0] r;
    for (int i = 0; i < NUM_REGS; i++) r[i*DATA_W +: DATA_W] = model_regs[i];
    return r;
  endfunction

  task automatic model_reset();
    dft_v = DFT;
    for (int i = 0; i < NUM_REGS; i++) model_regs[i] = dft_v[i*DATA_W +: DATA_W];
    model_err = 0;
  endtask

  task automatic model_err_inc();
    if (model_err < 255) model_err++;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    while (bus.rx_ready !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) begin
      n_cmp++; n_bad++;
      $display("FAIL rx_accept: rx_ready=%b, required 1", bus.rx_ready);
    end
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic do_write(input logic [7:0] a, input logic [DATA_W-1:0] d, input int gap);
    send_byte(8'hA5);
    repeat (gap) @(negedge clk);
    send_byte(a);
    for (int k = NB - 1; k >= 0; k--) begin
      repeat (gap) @(negedge clk);
      send_byte(d[k*8 +: 8]);
    end
  endtask

  // mode 0: tx_ready always high, 1: toggling 1/0, 2: random
  task automatic collect_word(input int mode, output logic [DATA_W-1:0] w);
    int got, cyc;
    logic hold, rdy;
    logic [7:0] hold_byte;
    got = 0; cyc = 0; hold = 1'b0; hold_byte = '0; w = '0;
    while (got < NB && cyc < 300) begin
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 2 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      if (hold) begin
        n_cmp++;
        if (bus.tx_valid !== 1'b1 || bus.tx_data !== hold_byte) begin
          n_bad++;
          $display("FAIL tx_hold: valid=%b data=%02h, required valid=1 data=%02h",
                   bus.tx_valid, bus.tx_data, hold_byte);
        end
      end
      bus.tx_ready = rdy;
      hold = 1'b0;
      if (bus.tx_valid === 1'b1) begin
        if (rdy) begin w = {w[DATA_W-9:0], bus.tx_data}; got++; end
        else begin hold = 1'b1; hold_byte = bus.tx_data; end
      end
      @(negedge clk);
      cyc++;
    end
    bus.tx_ready = 1'b0;
    n_cmp++;
    if (got < NB || bus.tx_valid !== 1'b0 || bus.rx_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL tx_end: bytes=%0d tx_valid=%b rx_ready=%b, required bytes=%0d tx_valid=0 rx_ready=1",
               got, bus.tx_valid, bus.rx_ready, NB);
    end
  endtask

  task automatic do_local_read(input logic [7:0] a, input int mode, output logic [DATA_W-1:0] w);
    send_byte(8'h5A);
    send_byte(a);
    n_cmp++;
    if (bus.tx_valid !== 1'b0) begin
      n_bad++; $display("FAIL local_lat1: tx_valid=%b, required 0", bus.tx_valid);
    end
    @(negedge clk);
    n_cmp++;
    if (bus.tx_valid !== 1'b1) begin
      n_bad++; $display("FAIL local_lat2: tx_valid=%b, required 1", bus.tx_valid);
    end
    collect_word(mode, w);
  endtask

  // delay < 0 means never acknowledge
  task automatic do_remote_read(input logic [7:0] a, input int delay, input logic [DATA_W-1:0] st,
                                input int mode, output logic [DATA_W-1:0] w, output int rr);
    int cyc;
    send_byte(8'h5A);
    send_byte(a);
    cyc = 0;
    n_cmp++;
    if (bus.read_req !== 1'b1 || bus.rx_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL rd_req_rise: read_req=%b rx_ready=%b, required 1/0", bus.read_req, bus.rx_ready);
    end
    while (bus.read_req === 1'b1 && cyc < ACK_TO + 20) begin
      n_cmp++;
      if (bus.uart_rd_addr !== a) begin
        n_bad++; $display("FAIL rd_addr: got %02h, required %02h", bus.uart_rd_addr, a);
      end
      cyc++;
      if (delay >= 0 && cyc == delay + 1) begin
        bus.read_ack = 1'b1; bus.status_bus = st;
      end else begin
        bus.status_bus = $urandom;
      end
      @(negedge clk);
      bus.read_ack = 1'b0;
    end
    rr = cyc;
    n_cmp++;
    if (bus.tx_valid !== 1'b1) begin
      n_bad++; $display("FAIL rd_tx_rise: tx_valid=%b, required 1", bus.tx_valid);
    end
    collect_word(mode, w);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    bus.rx_valid = 1'b0; bus.rx_data = '0; bus.tx_ready = 1'b0;
    bus.read_ack = 1'b0; bus.status_bus = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_reset();
    n_cmp++; if (ctrl_bus !== model_flat()) begin n_bad++; $display("FAIL rst_ctrl: got %h, required %h", ctrl_bus, model_flat()); end
    n_cmp++; if (ctrl_bus[3*DATA_W +: DATA_W] !== 32'h12345678) begin n_bad++; $display("FAIL rst_reg3: got %h, required 12345678", ctrl_bus[3*DATA_W +: DATA_W]); end
    n_cmp++; if (err_cnt !== 8'd0) begin n_bad++; $display("FAIL rst_err: got %0d, required 0", err_cnt); end
    n_cmp++; if (bus.rx_ready !== 1'b1) begin n_bad++; $display("FAIL rst_rx_ready: got %b, required 1", bus.rx_ready); end
    n_cmp++; if (bus.tx_valid !== 1'b0 || bus.tx_data !== 8'h00) begin n_bad++; $display("FAIL rst_tx: valid=%b data=%02h, required 0/00", bus.tx_valid, bus.tx_data); end
    n_cmp++; if (bus.read_req !== 1'b0 || bus.uart_rd_addr !== 8'h00) begin n_bad++; $display("FAIL rst_rd: req=%b addr=%02h, required 0/00", bus.read_req, bus.uart_rd_addr); end
    n_cmp++; if (wr_strobe !== '0) begin n_bad++; $display("FAIL rst_strobe: got %h, required 0", wr_strobe); end
    $display("txn reset: checked reset values");
  endtask

  task automatic test_write_basic();
    do_write(8'h02, 32'hDEADBEEF, 0);
    model_regs[2] = 32'hDEADBEEF;
    n_cmp++; if (ctrl_bus !== model_flat()) begin n_bad++; $display("FAIL wr_ctrl: got %h, required %h", ctrl_bus, model_flat()); end
    n_cmp++; if (wr_strobe !== 14'h0004) begin n_bad++; $display("FAIL wr_strobe_on: got %h, required 0004", wr_strobe); end
    @(negedge clk);
    n_cmp++; if (wr_strobe !== 14'h0000) begin n_bad++; $display("FAIL wr_strobe_off: got %h, required 0000", wr_strobe); end
    $display("txn write addr=02 data=deadbeef");
  endtask

  task automatic test_local_read();
    logic [DATA_W-1:0] w;
    do_local_read(8'h02, 1, w);
    n_cmp++; if (w !== 32'hDEADBEEF) begin n_bad++; $display("FAIL local_read: got %h, required deadbeef", w); end
    $display("txn local read addr=02 data=%h", w);
  endtask

  task automatic test_status_read();
    logic [DATA_W-1:0] w;
    int rr;
    do_remote_read(8'h80, 5, 32'hCAFEF00D, 0, w, rr);
    n_cmp++; if (w !== 32'hCAFEF00D) begin n_bad++; $display("FAIL status_data: got %h, required cafef00d", w); end
    n_cmp++; if (rr != 6) begin n_bad++; $display("FAIL status_req_len: got %0d, required 6", rr); end
    n_cmp++; if (err_cnt !== 8'(model_err)) begin n_bad++; $display("FAIL status_err: got %0d, required %0d", err_cnt, model_err); end
    $display("txn status read addr=80 data=%h", w);
  endtask

  task automatic test_ack_timeout();
    logic [DATA_W-1:0] w;
    int rr;
    do_remote_read(8'h80, -1, '0, 0, w, rr);
    model_err_inc();
    n_cmp++; if (w !== 32'hFFFFFFFF) begin n_bad++; $display("FAIL ackto_data: got %h, required ffffffff", w); end
    n_cmp++; if (rr != ACK_TO) begin n_bad++; $display("FAIL ackto_req_len: got %0d, required %0d", rr, ACK_TO); end
    n_cmp++; if (err_cnt !== 8'(model_err)) begin n_bad++; $display("FAIL ackto_err: got %0d, required %0d", err_cnt, model_err); end
    $display("txn status read timeout addr=80 data=%h err=%0d", w, err_cnt);
  endtask

  task automatic test_frame_timeout();
    int s0;
    apply_reset();
    s0 = strobe_pulses;
    send_byte(8'h33); model_err_inc();
    send_byte(8'hA5); send_byte(8'h05); send_byte(8'h11);
    repeat (FRAME_TO) @(negedge clk);
    model_err_inc();
    do_write(8'h20, 32'hDEADBEEF, 0); model_err_inc();
    repeat (3) @(negedge clk);
    n_cmp++; if (err_cnt !== 8'd3 || model_err != 3) begin n_bad++; $display("FAIL frame_err: got %0d, required 3", err_cnt); end
    n_cmp++; if (strobe_pulses != s0) begin n_bad++; $display("FAIL frame_strobe: got %0d pulses, required 0", strobe_pulses - s0); end
    n_cmp++; if (ctrl_bus !== model_flat()) begin n_bad++; $display("FAIL frame_ctrl: got %h, required %h", ctrl_bus, model_flat()); end
    $display("txn junk/timeout/bad-addr sequence err=%0d", err_cnt);
  endtask

  task automatic test_frame_gap_boundary();
    do_write(8'h07, 32'h7E57_0A11, FRAME_TO - 1);
    model_regs[7] = 32'h7E57_0A11;
    n_cmp++; if (wr_strobe !== 14'h0080) begin n_bad++; $display("FAIL gap_strobe: got %h, required 0080", wr_strobe); end
    n_cmp++; if (ctrl_bus !== model_flat()) begin n_bad++; $display("FAIL gap_ctrl: got %h, required %h", ctrl_bus, model_flat()); end
    n_cmp++; if (err_cnt !== 8'(model_err)) begin n_bad++; $display("FAIL gap_err: got %0d, required %0d", err_cnt, model_err); end
    $display("txn write with max gaps addr=07");
  endtask

  task automatic test_back_to_back();
    logic [DATA_W-1:0] w;
    do_write(8'h04, 32'h0102_0304, 0);
    model_regs[4] = 32'h0102_0304;
    do_local_read(8'h04, 0, w);
    n_cmp++; if (w !== model_regs[4]) begin n_bad++; $display("FAIL b2b_read: got %h, required %h", w, model_regs[4]); end
    do_write(8'h0D, 32'hA5A5_5A5A, 0);
    model_regs[13] = 32'hA5A5_5A5A;
    n_cmp++; if (ctrl_bus !== model_flat()) begin n_bad++; $display("FAIL b2b_ctrl: got %h, required %h", ctrl_bus, model_flat()); end
    $display("txn back-to-back write/read/write");
  endtask

  task automatic test_random();
    for (int t = 0; t < 40; t++) begin
      int kind, gap, delay, rr, mode;
      logic [7:0] a, b;
      logic [DATA_W-1:0] d, w;
      logic [NUM_REGS-1:0] exp_strobe;
      kind = $urandom_range(0, 3);
      mode = $urandom_range(0, 2);
      case (kind)
        0: begin
          a = 8'($urandom_range(0, NUM_REGS + 3));
          d = $urandom;
          gap = ($urandom_range(0, 7) == 0) ? FRAME_TO - 1 : $urandom_range(0, 2);
          do_write(a, d, gap);
          exp_strobe = '0;
          if (a < NUM_REGS) begin model_regs[a] = d; exp_strobe[a] = 1'b1; end
          else model_err_inc();
          n_cmp++; if (wr_strobe !== exp_strobe) begin n_bad++; $display("FAIL rnd_strobe: got %h, required %h", wr_strobe, exp_strobe); end
          n_cmp++; if (ctrl_bus !== model_flat()) begin n_bad++; $display("FAIL rnd_ctrl: got %h, required %h", ctrl_bus, model_flat()); end
          $display("txn %0d write addr=%02h data=%h gap=%0d", t, a, d, gap);
        end
        1: begin
          a = 8'($urandom_range(0, NUM_REGS - 1));
          do_local_read(a, mode, w);
          n_cmp++; if (w !== model_regs[a]) begin n_bad++; $display("FAIL rnd_local: got %h, required %h", w, model_regs[a]); end
          $display("txn %0d local read addr=%02h data=%h", t, a, w);
        end
        2: begin
          a = 8'($urandom_range(NUM_REGS, 255));
          d = $urandom;
          delay = $urandom_range(0, 10);
          do_remote_read(a, delay, d, mode, w, rr);
          n_cmp++; if (w !== d) begin n_bad++; $display("FAIL rnd_status: got %h, required %h", w, d); end
          n_cmp++; if (rr != delay + 1) begin n_bad++; $display("FAIL rnd_req_len: got %0d, required %0d", rr, delay + 1); end
          $display("txn %0d status read addr=%02h data=%h delay=%0d", t, a, w, delay);
        end
        default: begin
          do b = 8'($urandom_range(0, 255)); while (b == 8'hA5 || b == 8'h5A);
          send_byte(b);
          model_err_inc();
          $display("txn %0d junk byte %02h", t, b);
        end
      endcase
      n_cmp++; if (err_cnt !== 8'(model_err)) begin n_bad++; $display("FAIL rnd_err: got %0d, required %0d", err_cnt, model_err); end
    end
  endtask

  task automatic test_err_saturate();
    logic [7:0] b;
    for (int i = 0; i < 260; i++) begin
      do b = 8'($urandom_range(0, 255)); while (b == 8'hA5 || b == 8'h5A);
      send_byte(b);
      model_err_inc();
    end
    n_cmp++; if (err_cnt !== 8'd255 || model_err != 255) begin n_bad++; $display("FAIL err_sat: got %0d, required 255", err_cnt); end
    $display("txn 260 junk bytes err=%0d", err_cnt);
  endtask

  task automatic test_reset_midframe();
    logic [DATA_W-1:0] w;
    do_write(8'h03, 32'h5555_AAAA, 0);
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11);
    apply_reset();
    n_cmp++; if (ctrl_bus !== model_flat() || err_cnt !== 8'd0 || wr_strobe !== '0) begin
      n_bad++; $display("FAIL midrst_wr: ctrl=%h err=%0d strobe=%h, required %h/0/0", ctrl_bus, err_cnt, wr_strobe, model_flat());
    end
    send_byte(8'h5A); send_byte(8'h90);
    repeat (3) @(negedge clk);
    apply_reset();
    n_cmp++; if (bus.read_req !== 1'b0 || bus.rx_ready !== 1'b1) begin
      n_bad++; $display("FAIL midrst_rd: read_req=%b rx_ready=%b, required 0/1", bus.read_req, bus.rx_ready);
    end
    send_byte(8'h5A); send_byte(8'h03);
    @(negedge clk);
    apply_reset();
    n_cmp++; if (bus.tx_valid !== 1'b0 || bus.tx_data !== 8'h00) begin
      n_bad++; $display("FAIL midrst_tx: valid=%b data=%02h, required 0/00", bus.tx_valid, bus.tx_data);
    end
    do_write(8'h01, 32'h0F0E_0D0C, 0);
    model_regs[1] = 32'h0F0E_0D0C;
    n_cmp++; if (wr_strobe !== 14'h0002 || ctrl_bus !== model_flat()) begin
      n_bad++; $display("FAIL midrst_after: strobe=%h ctrl=%h, required 0002/%h", wr_strobe, ctrl_bus, model_flat());
    end
    do_local_read(8'h03, 2, w);
    n_cmp++; if (w !== 32'h12345678) begin n_bad++; $display("FAIL midrst_reg3: got %h, required 12345678", w); end
    $display("txn mid-frame resets and recovery");
  endtask

  initial begin
    test_reset();
    test_write_basic();
    test_local_read();
    test_status_read();
    test_ack_timeout();
    test_frame_timeout();
    test_frame_gap_boundary();
    test_back_to_back();
    test_random();
    test_err_saturate();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
